// File: rtl/led_blink_driver.sv
// led_blink_driver: stretches single-cycle event strobes into visible LED blinks, queueing overlapping events
module led_blink_driver #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned ON_MS       = 50,
    parameter int unsigned OFF_MS      = 50,
    parameter logic        IDLE_STATE  = 1'b1,
    parameter int unsigned MAX_PENDING = 15,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              event_in,
    input  logic              force_on,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam logic [31:0] CYC_PER_MS = 32'(CLK_HZ / 1000);
    localparam logic [31:0] ON_RAW     = 32'(ON_MS) * CYC_PER_MS;
    localparam logic [31:0] OFF_RAW    = 32'(OFF_MS) * CYC_PER_MS;
    localparam logic [31:0] ON_CYCLES  = (ON_RAW == 32'd0) ? 32'd1 : ON_RAW;
    localparam logic [31:0] OFF_CYCLES = (OFF_RAW == 32'd0) ? 32'd1 : OFF_RAW;
    localparam logic [31:0] ON_LAST    = ON_CYCLES - 32'd1;
    localparam logic [31:0] OFF_LAST   = OFF_CYCLES - 32'd1;
    localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PENDING);
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;
    state_t            state, state_nx;
    logic [31:0]       timer, timer_nx;
    logic [PEND_W-1:0] pending_nx;
    logic              led_nx, ovf_nx, on_done, off_done, restart;
    // next state, timer, pending queue and LED level; a restart out of OFF consumes one blink
    always_comb begin
        on_done    = (state == S_ON) && (timer == ON_LAST);
        off_done   = (state == S_OFF) && (timer == OFF_LAST);
        restart    = off_done && ((pending != '0) || event_in);
        state_nx   = state;
        pending_nx = pending;
        ovf_nx     = 1'b0;
        unique case (state)
            S_IDLE:  state_nx = event_in ? S_ON : S_IDLE;
            S_ON:    state_nx = on_done ? S_OFF : S_ON;
            S_OFF:   state_nx = off_done ? (restart ? S_ON : S_IDLE) : S_OFF;
            default: state_nx = S_IDLE;
        endcase
        timer_nx = ((state_nx != state) || (state == S_IDLE)) ? 32'd0 : timer + 32'd1;
        if (restart)
            pending_nx = event_in ? pending : pending - PEND_W'(1);
        else if (event_in && (state != S_IDLE)) begin
            if (pending == MAX_P)
                ovf_nx = 1'b1;
            else
                pending_nx = pending + PEND_W'(1);
        end
        led_nx = (force_on || (state_nx == S_ON)) ? ~IDLE_STATE : IDLE_STATE;
    end
    // state and all outputs are registered; reset aborts any blink and clears the queue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            timer    <= 32'd0;
            pending  <= '0;
            led_out  <= IDLE_STATE;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            pending  <= pending_nx;
            led_out  <= led_nx;
            busy     <= (state_nx != S_IDLE);
            overflow <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_led_blink_driver.sv
// tb_led_blink_driver: directed scoreboard bench for led_blink_driver (20-cycle blinks, 10-cycle gaps, queue depth 3)
module tb_led_blink_driver;
    logic       clk = 1'b0;
    logic       rstn, event_in, force_on;
    logic       led_out, busy, overflow;
    logic [3:0] pending;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string      tag;
        int         cyc;
        int         sig;
        logic [3:0] val;
    } exp_t;
    exp_t q[$];

    led_blink_driver #(
        .CLK_HZ(10000), .ON_MS(2), .OFF_MS(1), .IDLE_STATE(1'b1), .MAX_PENDING(3), .PEND_W(4)
    ) dut (
        .clk(clk), .rstn(rstn), .event_in(event_in), .force_on(force_on),
        .led_out(led_out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] pick(int sig);
        case (sig)
            0:       return {3'b0, led_out};
            1:       return {3'b0, busy};
            2:       return pending;
            default: return {3'b0, overflow};
        endcase
    endfunction

    // compare every expectation due in the current cycle, mid-cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                checks++;
                assert (pick(q[i].sig) === q[i].val) else begin
                    errors++;
                    $error("FAIL %s sig%0d cyc %0d observed %0h expected %0h",
                           q[i].tag, q[i].sig, cyc, pick(q[i].sig), q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic push(string tag, int c, int sig, logic [3:0] v);
        q.push_back('{tag, c, sig, v});
    endtask

    // n blinks from an event at t0; force_on high during cycles t0+f0..t0+f1 (empty when f0>f1)
    task automatic push_blinks(string tag, int t0, int n, int len, int f0, int f1);
        for (int k = 0; k <= len; k++) begin
            logic act, frc;
            act = (k >= 1) && (k <= 30 * n) && (((k - 1) % 30) < 20);
            frc = (k - 1 >= f0) && (k - 1 <= f1);
            push(tag, t0 + k, 0, {3'b0, !(act || frc)});
            push(tag, t0 + k, 1, {3'b0, (k >= 1) && (k <= 30 * n)});
        end
    endtask

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_at(int c);
        wait_to(c);
        event_in = 1'b1;
        step();
        event_in = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout observed %0d left expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int t0, t2;
        rstn = 1'b0;
        event_in = 1'b0;
        force_on = 1'b0;
        repeat (3) step();
        chk("reset_led", {3'b0, led_out}, 4'd1);
        chk("reset_busy", {3'b0, busy}, 4'd0);
        chk("reset_pend", pending, 4'd0);
        rstn = 1'b1;
        t0 = cyc + 1;
        push("idle_led", t0, 0, 4'd1);
        push("idle_ovf", t0, 3, 4'd0);
        drain(20);

        t0 = cyc + 2;
        push_blinks("single", t0, 1, 31, 1, 0);
        push("single_pend", t0 + 5, 2, 4'd0);
        push("single_pend", t0 + 25, 2, 4'd0);
        pulse_at(t0);
        drain(100);

        t0 = cyc + 2;
        push_blinks("queued", t0, 3, 91, 1, 0);
        push("queued_pend", t0 + 7, 2, 4'd2);
        push("queued_pend", t0 + 30, 2, 4'd2);
        push("queued_pend", t0 + 31, 2, 4'd1);
        push("queued_pend", t0 + 60, 2, 4'd1);
        push("queued_pend", t0 + 61, 2, 4'd0);
        pulse_at(t0);
        pulse_at(t0 + 5);
        pulse_at(t0 + 6);
        drain(200);

        t0 = cyc + 2;
        push_blinks("sat", t0, 4, 121, 1, 0);
        for (int k = 0; k <= 121; k++) push("sat_ovf", t0 + k, 3, {3'b0, k == 9});
        push("sat_pend", t0 + 7, 2, 4'd3);
        push("sat_pend", t0 + 10, 2, 4'd3);
        push("sat_pend", t0 + 31, 2, 4'd2);
        for (int k = 0; k <= 8; k += 2) pulse_at(t0 + k);
        drain(250);

        t0 = cyc + 2;
        push_blinks("simul", t0, 3, 91, 1, 0);
        push("simul_pend", t0 + 6, 2, 4'd1);
        push("simul_pend", t0 + 30, 2, 4'd1);
        push("simul_pend", t0 + 31, 2, 4'd1);
        push("simul_pend", t0 + 60, 2, 4'd1);
        push("simul_pend", t0 + 61, 2, 4'd0);
        push("simul_ovf", t0 + 31, 3, 4'd0);
        pulse_at(t0);
        pulse_at(t0 + 5);
        pulse_at(t0 + 30);
        drain(200);

        t0 = cyc + 2;
        push_blinks("force_idle", t0, 0, 13, 0, 10);
        push("force_idle_pend", t0 + 5, 2, 4'd0);
        wait_to(t0);
        force_on = 1'b1;
        wait_to(t0 + 11);
        force_on = 1'b0;
        drain(50);

        t0 = cyc + 2;
        push_blinks("force_blink", t0, 2, 62, 10, 40);
        push("force_pend", t0 + 4, 2, 4'd1);
        push("force_pend", t0 + 30, 2, 4'd1);
        push("force_pend", t0 + 31, 2, 4'd0);
        pulse_at(t0);
        pulse_at(t0 + 3);
        wait_to(t0 + 10);
        force_on = 1'b1;
        wait_to(t0 + 41);
        force_on = 1'b0;
        drain(150);

        t0 = cyc + 2;
        for (int k = 1; k <= 7; k++) push("pre_rst_led", t0 + k, 0, 4'd0);
        for (int k = 5; k <= 7; k++) push("pre_rst_pend", t0 + k, 2, 4'd1);
        pulse_at(t0);
        pulse_at(t0 + 3);
        wait_to(t0 + 8);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_led", {3'b0, led_out}, 4'd1);
        chk("async_busy", {3'b0, busy}, 4'd0);
        chk("async_pend", pending, 4'd0);
        step();
        step();
        #3;
        rstn = 1'b1;
        t2 = cyc;
        for (int k = 1; k <= 80; k++) begin
            push("post_rst_led", t2 + k, 0, 4'd1);
            push("post_rst_busy", t2 + k, 1, 4'd0);
        end
        push("post_rst_pend", t2 + 40, 2, 4'd0);
        drain(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_blink_driver.md
Name: led_blink_driver

Overview:
- Output-side counterpart of the input debouncer. The debouncer suppresses short input activity; this block stretches short internal event strobes into human-visible blinks on an indicator pin.
- Each single-cycle event produces one blink: ON for ON_MS, then a mandatory OFF gap of OFF_MS.
- Events that arrive while a blink is in progress are counted and replayed as additional blinks.
- Sits between status/event logic in the clk domain and a board LED pin.

Parameters:
CLK_HZ, 100000000, clk frequency in Hz; cycles per ms = CLK_HZ / 1000 (integer division).
ON_MS, 50, blink ON duration in ms; ON_CYCLES = ON_MS * (CLK_HZ / 1000), forced to at least 1.
OFF_MS, 50, minimum OFF gap after each blink in ms; OFF_CYCLES = OFF_MS * (CLK_HZ / 1000), forced to at least 1.
IDLE_STATE, 1'b1, led_out level when dark; the active level is ~IDLE_STATE.
MAX_PENDING, 15, saturation limit of the pending-event counter; must be at least 1.
PEND_W, 4, width of the pending output; must satisfy 2^PEND_W > MAX_PENDING.

Ports:
clk  input  1  single clock.
rstn  input  1  asynchronous active-low reset.
event_in  input  1  single-cycle blink request, synchronous to clk.
force_on  input  1  level input; while high, led_out is held active.
led_out  output  1  registered LED drive.
busy  output  1  high while the FSM is not IDLE.
pending  output  PEND_W  queued blinks not yet started.
overflow  output  1  one-cycle pulse when an event is dropped because pending is saturated.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, timer=0, pending=0, led_out=IDLE_STATE, busy=0, overflow=0. Release is synchronous to the next clk edge.
- FSM states: IDLE, ON, OFF. Timer is a 32-bit counter, cleared on every state change.
- IDLE, event_in=1: go to ON.
  - led_out becomes active on the same edge, i.e. 1-cycle latency from event_in.
  - pending is unchanged.
- ON: timer increments each cycle. When timer==ON_CYCLES-1, go to OFF. led_out is active for exactly ON_CYCLES cycles.
- OFF: led_out=IDLE_STATE (unless force_on). When timer==OFF_CYCLES-1:
  - if pending>0, or event_in=1 this cycle: go to ON; a blink is consumed.
  - else: go to IDLE.
- Pending counter:
  - event_in in ON or OFF increments pending, saturating at MAX_PENDING.
  - Increment attempted while pending==MAX_PENDING: event dropped, overflow pulses for 1 cycle.
  - The OFF->ON transition decrements pending.
  - event_in on that same transition cycle: net 0 change; the event is never dropped.
  - event_in on the last OFF cycle with pending==0: that event starts the next blink directly; pending stays 0.
- force_on:
  - Overrides the led_out value only: led_out = force_on ? ~IDLE_STATE : FSM value, registered, 1-cycle latency.
  - FSM, timer and pending continue unaffected.
- busy = (state != IDLE), registered together with the state.
- Back-to-back blinks are always separated by exactly OFF_CYCLES dark cycles, never fewer.
- Reset asserted mid-blink aborts immediately: led_out=IDLE_STATE and the queue is cleared. No blink resumes after release.
- Widths: all comparisons are done at 32 bits, with ON_CYCLES and OFF_CYCLES computed as 32-bit localparams.

Test Plan:
Use CLK_HZ=10000 (10 cycles/ms), ON_MS=2, OFF_MS=1, so ON_CYCLES=20 and OFF_CYCLES=10; IDLE_STATE=1, MAX_PENDING=3.
- Reset state: assert rstn=0 asynchronously, between clk edges, mid-ON -> led_out=1, busy=0, pending=0 immediately, with no clk edge. After release, no further blinks occur.
- Single event: event_in pulse at cycle 0 -> led_out=0 for cycles 1-20, led_out=1 for cycles 21-30, busy falls at cycle 31, pending stays 0 throughout.
- Queued events: 3 pulses at cycles 0, 5, 6 -> pending goes to 2. Three blinks start at cycles 1, 31, 61, each 20 cycles long with 10-cycle gaps. pending reads 1 after cycle 31 and 0 after cycle 61; busy returns to 0 at cycle 91.
- Saturation: 5 pulses during one ON phase -> pending=3 and overflow pulses exactly once, on the 5th event. Exactly 4 blinks total.
- Simultaneous event and dequeue: pending=1, event_in on the final OFF cycle -> pending stays 1 and the next blink starts on schedule.
- force_on: force_on held high for cycles 40-50 while idle -> led_out=0 during cycles 41-51, busy=0, pending=0. Then with force_on high across a blink -> blink timing and pending are unchanged.
